// File: rtl/core_pkg.sv
// Shared core definitions: MEM-stage FSM states, entry kinds, funct3 load/store
// codes and the store byte-enable helper.
package core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LOAD_WAIT  = 2'd1,
        ST_STORE_WAIT = 2'd2
    } mem_state_e;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_ALU   = 2'd1,
        OP_LOAD  = 2'd2,
        OP_STORE = 2'd3
    } mem_op_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte enables for a store; unknown size codes behave as a full word.
    function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (funct3)
            F3_B:    be = 4'b0001 << addr_lo;
            F3_H:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory bus bundle between the MEM stage (master) and the data memory (slave).
interface mem_wb_stage_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      be;
    logic            ack;
    logic [XLEN-1:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ack, rdata
    );
endinterface

// File: rtl/mem_wb_stage_load_align.sv
// Load lane selection and sign/zero extension of the raw data-memory word.
module load_align
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and halfword out of the word.
    always_comb begin
        byte_s = 8'h00;
        case (addr_lo)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Extend according to access size; unknown codes return the whole word.
    always_comb begin
        data = rdata;
        case (funct3)
            F3_B:    data = {{(XLEN-8){byte_s[7]}}, byte_s};
            F3_H:    data = {{(XLEN-16){half_s[15]}}, half_s};
            F3_BU:   data = {{(XLEN-8){1'b0}}, byte_s};
            F3_HU:   data = {{(XLEN-16){1'b0}}, half_s};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: holds one MEM entry, runs the data-memory handshake for
// loads and stores, and drives the register-file write port and forwarding outputs.
module mem_wb_stage
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,

    input  logic            ex_valid_i,
    input  logic [4:0]      ex_rd_index_r,
    input  logic [XLEN-1:0] ex_alu_res_r,
    input  logic [XLEN-1:0] ex_rb_value_i,
    input  logic            ex_mem_rd_i,
    input  logic            ex_mem_wr_i,
    input  logic [2:0]      ex_funct3_i,

    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    output logic [3:0]      dmem_be_o,
    input  logic            dmem_ack_i,
    input  logic [XLEN-1:0] dmem_rdata_i,

    output logic [4:0]      mem_rd_index_w,
    output logic [XLEN-1:0] mem_wb_alu_result_r,
    output logic [XLEN-1:0] mem_rdata_w,
    output logic            mem_access_w,

    output logic            stall_o,

    output logic            rf_we_o,
    output logic [4:0]      rf_waddr_o,
    output logic [XLEN-1:0] rf_wdata_o
);

    mem_state_e      state_r;
    mem_op_e         op_r;
    logic [4:0]      rd_r;
    logic [XLEN-1:0] result_r;
    logic [2:0]      funct3_r;
    logic [XLEN-1:0] rdata_r;
    logic [XLEN-1:0] wdata_r;
    logic [3:0]      be_r;

    mem_op_e         next_op_s;
    logic [XLEN-1:0] load_data_s;
    logic            fwd_valid_s;

    // Replicate the narrow store datum across every lane so the memory can pick any.
    function automatic logic [XLEN-1:0] store_wdata(input logic [2:0] funct3, input logic [XLEN-1:0] value);
        logic [XLEN-1:0] w;
        case (funct3)
            F3_B:    w = {(XLEN/8){value[7:0]}};
            F3_H:    w = {(XLEN/16){value[15:0]}};
            default: w = value;
        endcase
        return w;
    endfunction

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata   (dmem_rdata_i),
        .addr_lo (result_r[1:0]),
        .funct3  (funct3_r),
        .data    (load_data_s)
    );

    // Classify the incoming EX instruction; a store wins when both strobes are set.
    always_comb begin
        next_op_s = OP_ALU;
        if (ex_mem_wr_i) begin
            next_op_s = OP_STORE;
        end else if (ex_mem_rd_i) begin
            next_op_s = OP_LOAD;
        end else begin
            next_op_s = OP_ALU;
        end
    end

    // MEM register and access FSM.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r  <= ST_IDLE;
            op_r     <= OP_NONE;
            rd_r     <= 5'd0;
            result_r <= {XLEN{1'b0}};
            funct3_r <= 3'b000;
            rdata_r  <= {XLEN{1'b0}};
            wdata_r  <= {XLEN{1'b0}};
            be_r     <= 4'b0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ex_valid_i) begin
                        op_r     <= next_op_s;
                        rd_r     <= ex_rd_index_r;
                        result_r <= ex_alu_res_r;
                        funct3_r <= ex_funct3_i;
                        wdata_r  <= store_wdata(ex_funct3_i, ex_rb_value_i);
                        if (next_op_s == OP_STORE) begin
                            be_r    <= store_be(ex_funct3_i, ex_alu_res_r[1:0]);
                            state_r <= ST_STORE_WAIT;
                        end else if (next_op_s == OP_LOAD) begin
                            be_r    <= 4'b1111;
                            state_r <= ST_LOAD_WAIT;
                        end else begin
                            be_r    <= 4'b0000;
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        op_r     <= OP_NONE;
                        rd_r     <= 5'd0;
                        result_r <= {XLEN{1'b0}};
                        be_r     <= 4'b0000;
                        state_r  <= ST_IDLE;
                    end
                end
                ST_LOAD_WAIT: begin
                    if (dmem_ack_i) begin
                        rdata_r <= load_data_s;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_LOAD_WAIT;
                    end
                end
                ST_STORE_WAIT: begin
                    if (dmem_ack_i) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_STORE_WAIT;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus and stall outputs come straight from state; reset masks them at once.
    always_comb begin
        dmem_req_o   = (state_r != ST_IDLE) && !reset_i;
        dmem_we_o    = (state_r == ST_STORE_WAIT) && !reset_i;
        stall_o      = (state_r != ST_IDLE) && !reset_i;
        dmem_addr_o  = {result_r[XLEN-1:2], 2'b00};
        dmem_wdata_o = wdata_r;
        dmem_be_o    = be_r;
    end

    // Only a completed, non-store entry is a forwarding/writeback source.
    always_comb begin
        fwd_valid_s         = (state_r == ST_IDLE) && ((op_r == OP_ALU) || (op_r == OP_LOAD));
        mem_rd_index_w      = fwd_valid_s ? rd_r : 5'd0;
        mem_access_w        = (op_r == OP_LOAD);
        mem_wb_alu_result_r = result_r;
        mem_rdata_w         = rdata_r;
        rf_we_o             = (mem_rd_index_w != 5'd0) && !reset_i;
        rf_waddr_o          = mem_rd_index_w;
        rf_wdata_o          = mem_access_w ? rdata_r : result_r;
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage with hand-computed expectations.
module tb_mem_wb_stage;

    logic        clk;
    logic        reset_i;
    logic        ex_valid_i;
    logic [4:0]  ex_rd_index_r;
    logic [31:0] ex_alu_res_r;
    logic [31:0] ex_rb_value_i;
    logic        ex_mem_rd_i;
    logic        ex_mem_wr_i;
    logic [2:0]  ex_funct3_i;
    logic [4:0]  mem_rd_index_w;
    logic [31:0] mem_wb_alu_result_r;
    logic [31:0] mem_rdata_w;
    logic        mem_access_w;
    logic        stall_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;

    int tests = 0;
    int fails = 0;

    mem_wb_stage_if #(.XLEN(32)) dmem ();

    mem_wb_stage #(.XLEN(32)) dut (
        .clk_i               (clk),
        .reset_i             (reset_i),
        .ex_valid_i          (ex_valid_i),
        .ex_rd_index_r       (ex_rd_index_r),
        .ex_alu_res_r        (ex_alu_res_r),
        .ex_rb_value_i       (ex_rb_value_i),
        .ex_mem_rd_i         (ex_mem_rd_i),
        .ex_mem_wr_i         (ex_mem_wr_i),
        .ex_funct3_i         (ex_funct3_i),
        .dmem_req_o          (dmem.req),
        .dmem_we_o           (dmem.we),
        .dmem_addr_o         (dmem.addr),
        .dmem_wdata_o        (dmem.wdata),
        .dmem_be_o           (dmem.be),
        .dmem_ack_i          (dmem.ack),
        .dmem_rdata_i        (dmem.rdata),
        .mem_rd_index_w      (mem_rd_index_w),
        .mem_wb_alu_result_r (mem_wb_alu_result_r),
        .mem_rdata_w         (mem_rdata_w),
        .mem_access_w        (mem_access_w),
        .stall_o             (stall_o),
        .rf_we_o             (rf_we_o),
        .rf_waddr_o          (rf_waddr_o),
        .rf_wdata_o          (rf_wdata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Present one EX instruction for a single edge, then drop ex_valid_i.
    task automatic issue(input logic [4:0] rd, input logic [31:0] res, input logic [31:0] rb,
                         input logic rd_op, input logic wr_op, input logic [2:0] f3);
        ex_valid_i = 1'b1; ex_rd_index_r = rd; ex_alu_res_r = res; ex_rb_value_i = rb;
        ex_mem_rd_i = rd_op; ex_mem_wr_i = wr_op; ex_funct3_i = f3;
        step();
        ex_valid_i = 1'b0; ex_mem_rd_i = 1'b0; ex_mem_wr_i = 1'b0;
    endtask

    task automatic test_reset;
        reset_i = 1'b1;
        step();
        step();
        tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL reset_stall: got %0b want 0", stall_o); end
        tests++; if (dmem.req !== 1'b0) begin fails++; $display("FAIL reset_req: got %0b want 0", dmem.req); end
        tests++; if (rf_we_o !== 1'b0) begin fails++; $display("FAIL reset_rf_we: got %0b want 0", rf_we_o); end
        tests++; if (mem_rd_index_w !== 5'd0) begin fails++; $display("FAIL reset_rd: got %0d want 0", mem_rd_index_w); end
        tests++; if (rf_wdata_o !== 32'h0) begin fails++; $display("FAIL reset_wdata: got %h want 0", rf_wdata_o); end
        tests++; if (mem_rdata_w !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", mem_rdata_w); end
        reset_i = 1'b0;
        step();
    endtask

    task automatic test_alu;
        issue(5'd5, 32'h0000_1234, 32'h0, 1'b0, 1'b0, 3'b000);
        tests++; if (mem_rd_index_w !== 5'd5) begin fails++; $display("FAIL alu_rd: got %0d want 5", mem_rd_index_w); end
        tests++; if (rf_wdata_o !== 32'h0000_1234) begin fails++; $display("FAIL alu_wdata: got %h want 00001234", rf_wdata_o); end
        tests++; if (rf_we_o !== 1'b1) begin fails++; $display("FAIL alu_we: got %0b want 1", rf_we_o); end
        tests++; if (rf_waddr_o !== 5'd5) begin fails++; $display("FAIL alu_waddr: got %0d want 5", rf_waddr_o); end
        tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL alu_stall: got %0b want 0", stall_o); end
        tests++; if (mem_access_w !== 1'b0) begin fails++; $display("FAIL alu_access: got %0b want 0", mem_access_w); end
        step();
        tests++; if (rf_we_o !== 1'b0) begin fails++; $display("FAIL alu_bubble_we: got %0b want 0", rf_we_o); end
    endtask

    task automatic test_load_byte;
        int stall_cycles;
        issue(5'd7, 32'h0000_0103, 32'h0, 1'b1, 1'b0, 3'b000);
        stall_cycles = 0;
        tests++; if (dmem.addr !== 32'h0000_0100) begin fails++; $display("FAIL lb_addr: got %h want 00000100", dmem.addr); end
        tests++; if (dmem.we !== 1'b0) begin fails++; $display("FAIL lb_we: got %0b want 0", dmem.we); end
        tests++; if (rf_we_o !== 1'b0) begin fails++; $display("FAIL lb_pending_we: got %0b want 0", rf_we_o); end
        // Junk on the EX side while stalled must be ignored.
        ex_valid_i = 1'b1; ex_rd_index_r = 5'd12; ex_alu_res_r = 32'h999; ex_mem_wr_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (stall_o === 1'b1 && dmem.req === 1'b1) stall_cycles++;
            if (i == 3) begin
                dmem.ack = 1'b1; dmem.rdata = 32'h80FF_FFFF;
            end
            step();
        end
        dmem.ack = 1'b0; dmem.rdata = 32'h0;
        ex_valid_i = 1'b0; ex_mem_wr_i = 1'b0;
        tests++; if (stall_cycles !== 4) begin fails++; $display("FAIL lb_stall_cycles: got %0d want 4", stall_cycles); end
        tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL lb_stall_end: got %0b want 0", stall_o); end
        tests++; if (rf_wdata_o !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb_wdata: got %h want ffffff80", rf_wdata_o); end
        tests++; if (mem_access_w !== 1'b1) begin fails++; $display("FAIL lb_access: got %0b want 1", mem_access_w); end
        tests++; if (mem_rd_index_w !== 5'd7) begin fails++; $display("FAIL lb_rd: got %0d want 7", mem_rd_index_w); end
        tests++; if (rf_we_o !== 1'b1) begin fails++; $display("FAIL lb_we_after: got %0b want 1", rf_we_o); end
        step();
        tests++; if (rf_we_o !== 1'b0) begin fails++; $display("FAIL lb_once: got %0b want 0", rf_we_o); end
    endtask

    task automatic test_load_variants;
        logic [31:0] addrs [6] = '{32'h102, 32'h100, 32'h101, 32'h10F, 32'h200, 32'h100};
        logic [2:0]  f3s   [6] = '{3'b001, 3'b101, 3'b100, 3'b010, 3'b011, 3'b000};
        logic [31:0] rdat  [6] = '{32'h8001_1234, 32'h1234_F00D, 32'h1234_A5F0, 32'hDEAD_BEEF, 32'h8765_4321, 32'h0000_007F};
        logic [31:0] exps  [6] = '{32'hFFFF_8001, 32'h0000_F00D, 32'h0000_00A5, 32'hDEAD_BEEF, 32'h8765_4321, 32'h0000_007F};
        logic [31:0] waddr [6] = '{32'h100, 32'h100, 32'h100, 32'h10C, 32'h200, 32'h100};
        for (int k = 0; k < 6; k++) begin
            issue(5'd10, addrs[k], 32'h0, 1'b1, 1'b0, f3s[k]);
            tests++; if (dmem.addr !== waddr[k]) begin fails++; $display("FAIL ld%0d_addr: got %h want %h", k, dmem.addr, waddr[k]); end
            dmem.ack = 1'b1; dmem.rdata = rdat[k];
            step();
            dmem.ack = 1'b0; dmem.rdata = 32'h0;
            tests++; if (rf_wdata_o !== exps[k]) begin fails++; $display("FAIL ld%0d_data: got %h want %h", k, rf_wdata_o, exps[k]); end
            step();
        end
    endtask

    task automatic test_store;
        logic [31:0] addrs [4] = '{32'h102, 32'h101, 32'h204, 32'h103};
        logic [31:0] rbs   [4] = '{32'h0000_ABCD, 32'h1234_565A, 32'h1122_3344, 32'h0000_00C3};
        logic [2:0]  f3s   [4] = '{3'b001, 3'b000, 3'b010, 3'b000};
        logic        rdo   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [3:0]  bes   [4] = '{4'b1100, 4'b0010, 4'b1111, 4'b1000};
        logic [31:0] wds   [4] = '{32'hABCD_ABCD, 32'h5A5A_5A5A, 32'h1122_3344, 32'hC3C3_C3C3};
        for (int k = 0; k < 4; k++) begin
            issue(5'd9, addrs[k], rbs[k], rdo[k], 1'b1, f3s[k]);
            step();
            tests++; if (dmem.be !== bes[k]) begin fails++; $display("FAIL st%0d_be: got %b want %b", k, dmem.be, bes[k]); end
            tests++; if (dmem.wdata !== wds[k]) begin fails++; $display("FAIL st%0d_wdata: got %h want %h", k, dmem.wdata, wds[k]); end
            tests++; if (dmem.we !== 1'b1 || dmem.req !== 1'b1) begin fails++; $display("FAIL st%0d_we_req: got %b%b want 11", k, dmem.we, dmem.req); end
            tests++; if (mem_rd_index_w !== 5'd0 || rf_we_o !== 1'b0) begin fails++; $display("FAIL st%0d_no_wb: got rd %0d we %0b want 0 0", k, mem_rd_index_w, rf_we_o); end
            dmem.ack = 1'b1;
            step();
            dmem.ack = 1'b0;
            tests++; if (stall_o !== 1'b0 || dmem.req !== 1'b0 || rf_we_o !== 1'b0) begin fails++; $display("FAIL st%0d_done: got stall %0b req %0b we %0b want 000", k, stall_o, dmem.req, rf_we_o); end
        end
    endtask

    task automatic test_x0_stray_ack;
        issue(5'd0, 32'h0000_0055, 32'h0, 1'b0, 1'b0, 3'b000);
        tests++; if (rf_we_o !== 1'b0 || mem_rd_index_w !== 5'd0) begin fails++; $display("FAIL x0_we: got we %0b rd %0d want 0 0", rf_we_o, mem_rd_index_w); end
        tests++; if (mem_wb_alu_result_r !== 32'h55) begin fails++; $display("FAIL x0_result: got %h want 00000055", mem_wb_alu_result_r); end
        dmem.ack = 1'b1;
        step();
        step();
        dmem.ack = 1'b0;
        tests++; if (stall_o !== 1'b0 || dmem.req !== 1'b0) begin fails++; $display("FAIL stray_ack: got stall %0b req %0b want 0 0", stall_o, dmem.req); end
    endtask

    task automatic test_reset_mid_wait;
        issue(5'd4, 32'h0000_0300, 32'h0, 1'b1, 1'b0, 3'b010);
        tests++; if (stall_o !== 1'b1) begin fails++; $display("FAIL rst_wait_stall: got %0b want 1", stall_o); end
        reset_i = 1'b1;
        #1;
        tests++; if (dmem.req !== 1'b0 || stall_o !== 1'b0) begin fails++; $display("FAIL rst_immediate: got req %0b stall %0b want 0 0", dmem.req, stall_o); end
        step();
        tests++; if (mem_rd_index_w !== 5'd0 || mem_access_w !== 1'b0) begin fails++; $display("FAIL rst_cleared: got rd %0d access %0b want 0 0", mem_rd_index_w, mem_access_w); end
        reset_i = 1'b0;
        step();
        tests++; if (stall_o !== 1'b0 || rf_we_o !== 1'b0 || dmem.req !== 1'b0) begin fails++; $display("FAIL rst_idle: got stall %0b we %0b req %0b want 000", stall_o, rf_we_o, dmem.req); end
    endtask

    task automatic test_back_to_back;
        ex_valid_i = 1'b1; ex_mem_rd_i = 1'b0; ex_mem_wr_i = 1'b0; ex_funct3_i = 3'b000;
        ex_rd_index_r = 5'd1; ex_alu_res_r = 32'h11;
        step();
        tests++; if (rf_waddr_o !== 5'd1 || rf_wdata_o !== 32'h11) begin fails++; $display("FAIL b2b_first: got %0d/%h want 1/00000011", rf_waddr_o, rf_wdata_o); end
        ex_rd_index_r = 5'd2; ex_alu_res_r = 32'h22;
        step();
        ex_valid_i = 1'b0;
        tests++; if (rf_waddr_o !== 5'd2 || rf_wdata_o !== 32'h22) begin fails++; $display("FAIL b2b_second: got %0d/%h want 2/00000022", rf_waddr_o, rf_wdata_o); end
        step();
    endtask

    initial begin
        reset_i = 1'b1; ex_valid_i = 1'b0; ex_rd_index_r = 5'd0; ex_alu_res_r = 32'h0;
        ex_rb_value_i = 32'h0; ex_mem_rd_i = 1'b0; ex_mem_wr_i = 1'b0; ex_funct3_i = 3'b000;
        dmem.ack = 1'b0; dmem.rdata = 32'h0;
        test_reset();
        test_alu();
        test_load_byte();
        test_load_variants();
        test_store();
        test_x0_stray_ack();
        test_reset_mid_wait();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have clk_i  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have reset_i  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ex_valid_i  in  1  EX holds a valid instruction for MEM.
REQ-005 SHALL have ex_rd_index_r  in  5  destination register of the EX instruction.
REQ-006 SHALL have ex_alu_res_r  in  XLEN  ALU result; memory address for loads and stores.
REQ-007 SHALL have ex_rb_value_i  in  XLEN  store data.
REQ-008 SHALL have ex_mem_rd_i / ex_mem_wr_i  in  1 each  load / store; both high is treated as store.
REQ-009 SHALL have ex_funct3_i  in  3  access size and signedness.
REQ-010 SHALL have dmem_req_o, dmem_we_o  out  1 each  data-memory request and write enable.
REQ-011 SHALL have dmem_addr_o  out  XLEN; dmem_wdata_o  out  XLEN; dmem_be_o  out  4.
REQ-012 SHALL have dmem_ack_i  in  1; dmem_rdata_i  in  XLEN  read data, valid with ack.
REQ-013 SHALL have mem_rd_index_w  out  5; mem_wb_alu_result_r  out  XLEN; mem_rdata_w  out  XLEN; mem_access_w  out  1  forwarding-source outputs.
REQ-014 SHALL have stall_o  out  1  hold IF/ID/EX.
REQ-015 SHALL have rf_we_o  out  1; rf_waddr_o  out  5; rf_wdata_o  out  XLEN  register-file write port.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD_WAIT, STORE_WAIT.
REQ-017 SHALL, in IDLE with ex_valid_i=1 at an edge: capture rd, ALU result, funct3 and op into the MEM register; load -> LOAD_WAIT, store -> STORE_WAIT, else remain IDLE.
REQ-018 SHALL ignore all EX inputs while stall_o=1; ex_valid_i=0 in IDLE loads a bubble (rd=0, not valid).
REQ-019 SHALL drive stall_o = (state != IDLE), registered only, no combinational path from dmem_ack_i.
REQ-020 SHALL hold dmem_req_o=1 for every cycle in LOAD_WAIT/STORE_WAIT, address/data/be stable, until dmem_ack_i=1.
REQ-021 SHALL drive dmem_addr_o = {result[XLEN-1:2], 2'b00}; dmem_we_o=1 only in STORE_WAIT.
REQ-022 SHALL ignore dmem_ack_i while in IDLE.
REQ-023 SHALL, on ack in LOAD_WAIT, register the extended load data into mem_rdata_w and return to IDLE; on ack in STORE_WAIT return to IDLE.
REQ-024 SHALL extend loads per funct3: 000 LB sign, 001 LH sign, 010 LW, 100 LBU, 101 LHU, other codes as LW; byte lane = addr[1:0], half lane = addr[1], word ignores addr[1:0].
REQ-025 SHALL, for stores, set be: SB 0001<<addr[1:0], SH 0011<<(2*addr[1]), SW 1111; replicate the store byte/half across all lanes of dmem_wdata_o.
REQ-026 SHALL drive mem_rd_index_w = MEM rd when the MEM entry is a valid non-store and state is IDLE; 0 otherwise (bubble, store, load pending).
REQ-027 SHALL drive mem_access_w=1 when the MEM entry is a load; mem_wb_alu_result_r = registered ALU result.
REQ-028 SHALL drive rf_we_o = (mem_rd_index_w != 0); rf_waddr_o = mem_rd_index_w; rf_wdata_o = mem_access_w ? mem_rdata_w : mem_wb_alu_result_r.
REQ-029 SHALL give latency: ALU op visible on outputs 1 cycle after acceptance; load visible 1 cycle after the ack edge; each MEM entry written exactly once.

Reset
REQ-030 SHALL, on an edge with reset_i=1: state IDLE, MEM register cleared (rd 0, result 0, rdata 0, op none).
REQ-031 SHALL gate dmem_req_o, dmem_we_o, stall_o and rf_we_o to 0 whenever reset_i=1; reset mid-wait abandons the access with no register write.

Structure
REQ-032 SHALL place the FSM state enum and funct3 load/store codes in the shared core_pkg.
REQ-033 SHALL implement lane select and extension in one sub-module, load_align.

Verification
REQ-034 ADD x5 result 0x0000_1234, ex_valid_i=1 -> next cycle mem_rd_index_w=5, rf_wdata_o=0x1234, rf_we_o=1, stall_o=0.
REQ-035 LB addr 0x103, rdata 0x80FF_FFFF, ack after 3 wait cycles -> stall_o=1 for 4 cycles, then rf_wdata_o=0xFFFF_FF80, mem_access_w=1.
REQ-036 SH addr 0x102, data 0xABCD -> dmem_be_o=1100, dmem_wdata_o=0xABCD_ABCD, dmem_we_o=1, mem_rd_index_w=0, rf_we_o=0.
REQ-037 ALU op to x0 -> rf_we_o=0, mem_rd_index_w=0; stray dmem_ack_i in IDLE -> no state change.
REQ-038 reset_i=1 during LOAD_WAIT -> dmem_req_o=0 and stall_o=0 immediately, state IDLE after the edge, no rf write.
